// File: rtl/ysyx_cmu_if.sv
// ROB commit slot handshake between the reorder buffer (master) and the commit unit (slave).
interface ysyx_cmu_if #(
  parameter int XLEN = 32,
  parameter int PLEN = 6
);
  logic            cmu_valid;
  logic [4:0]      cmu_rd;
  logic [31:0]     cmu_inst;
  logic [XLEN-1:0] cmu_pc;
  logic [XLEN-1:0] cmu_npc;
  logic            cmu_btaken;
  logic            cmu_ben;
  logic            cmu_jen;
  logic            cmu_jren;
  logic [PLEN-1:0] cmu_prd;
  logic [PLEN-1:0] cmu_prs;
  logic            cmu_ebreak;
  logic            cmu_fence_time;
  logic            cmu_fence_i;
  logic            cmu_flush_pipe;
  logic            cmu_ready;

  modport master (
    output cmu_valid, cmu_rd, cmu_inst, cmu_pc, cmu_npc, cmu_btaken, cmu_ben, cmu_jen,
           cmu_jren, cmu_prd, cmu_prs, cmu_ebreak, cmu_fence_time, cmu_fence_i,
           cmu_flush_pipe,
    input  cmu_ready
  );

  modport slave (
    input  cmu_valid, cmu_rd, cmu_inst, cmu_pc, cmu_npc, cmu_btaken, cmu_ben, cmu_jen,
           cmu_jren, cmu_prd, cmu_prs, cmu_ebreak, cmu_fence_time, cmu_fence_i,
           cmu_flush_pipe,
    output cmu_ready
  );
endinterface

// File: rtl/ysyx_cmu.sv
// Commit unit: retires one ROB slot per cycle, updates RAT/free list/BPU, sequences fence.i and ebreak.
// Optional performance counters are built only when YSYX_CMU_PERF_EN is defined.
module ysyx_cmu #(
  parameter int XLEN = 32,
  parameter int PLEN = 6
) (
  input  logic            clock,
  input  logic            reset,
  ysyx_cmu_if.slave       cmu,
  output logic            rat_wen,
  output logic [4:0]      rat_rd,
  output logic [PLEN-1:0] rat_prd,
  output logic            fl_wen,
  output logic [PLEN-1:0] fl_pr,
  output logic            bpu_wen,
  output logic [XLEN-1:0] bpu_pc,
  output logic [XLEN-1:0] bpu_npc,
  output logic            bpu_taken,
  output logic            bpu_jr,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            icache_flush_req,
  input  logic            icache_flush_ack,
  output logic            halt,
  output logic [63:0]     perf_commit,
  output logic [31:0]     perf_flush
);

  typedef enum logic [1:0] {ST_IDLE, ST_FENCE, ST_HALT} state_t;

  state_t          state, state_nxt;
  logic            fire;
  logic            do_flush;
  logic            fence_done;
  logic [XLEN-1:0] fence_pc;

  assign cmu.cmu_ready     = (state == ST_IDLE);
  assign fire              = cmu.cmu_valid & cmu.cmu_ready;
  assign icache_flush_req  = (state == ST_FENCE);
  assign halt              = (state == ST_HALT);

  // The raw instruction word travels with the slot for debug only.
  logic unused_inst;
  assign unused_inst = ^cmu.cmu_inst;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt  = state;
    do_flush   = 1'b0;
    fence_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          // ebreak beats fence.i beats a plain pipeline flush.
          if (cmu.cmu_ebreak)
            state_nxt = ST_HALT;
          else if (cmu.cmu_fence_i)
            state_nxt = ST_FENCE;
          else if (cmu.cmu_flush_pipe | cmu.cmu_fence_time)
            do_flush = 1'b1;
        end
      end
      ST_FENCE: begin
        if (icache_flush_ack) begin
          state_nxt  = ST_IDLE;
          do_flush   = 1'b1;
          fence_done = 1'b1;
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rat_wen     <= 1'b0;
      rat_rd      <= '0;
      rat_prd     <= '0;
      fl_wen      <= 1'b0;
      fl_pr       <= '0;
      bpu_wen     <= 1'b0;
      bpu_pc      <= '0;
      bpu_npc     <= '0;
      bpu_taken   <= 1'b0;
      bpu_jr      <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      fence_pc    <= '0;
    end else begin
      rat_wen <= fire && (cmu.cmu_rd != 5'd0);
      fl_wen  <= fire && (cmu.cmu_rd != 5'd0) && (cmu.cmu_prs != '0);
      bpu_wen <= fire && (cmu.cmu_ben | cmu.cmu_jen | cmu.cmu_jren);
      flush   <= do_flush;
      // Data outputs only move alongside their pulse, otherwise they hold.
      if (fire && (cmu.cmu_rd != 5'd0)) begin
        rat_rd  <= cmu.cmu_rd;
        rat_prd <= cmu.cmu_prd;
      end
      if (fire && (cmu.cmu_rd != 5'd0) && (cmu.cmu_prs != '0))
        fl_pr <= cmu.cmu_prs;
      if (fire && (cmu.cmu_ben | cmu.cmu_jen | cmu.cmu_jren)) begin
        bpu_pc    <= cmu.cmu_pc;
        bpu_npc   <= cmu.cmu_npc;
        bpu_taken <= cmu.cmu_btaken | cmu.cmu_jen | cmu.cmu_jren;
        bpu_jr    <= cmu.cmu_jren;
      end
      if (do_flush)
        redirect_pc <= fence_done ? fence_pc : cmu.cmu_npc;
      if (state == ST_IDLE && state_nxt == ST_FENCE)
        fence_pc <= cmu.cmu_pc + XLEN'(4);
    end
  end

`ifdef YSYX_CMU_PERF_EN
  logic [63:0] commit_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (fire)     commit_cnt <= commit_cnt + 64'd1;
      if (do_flush) flush_cnt  <= flush_cnt + 32'd1;
    end
  end

  assign perf_commit = commit_cnt;
  assign perf_flush  = flush_cnt;
`else
  assign perf_commit = '0;
  assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_ysyx_cmu.sv
// Directed self-checking bench for ysyx_cmu: commit effects, flush, fence.i handshake, ebreak halt, counters.
module tb_ysyx_cmu;
  localparam int XLEN = 32;
  localparam int PLEN = 6;

  logic            clock;
  logic            reset;
  logic            rat_wen;
  logic [4:0]      rat_rd;
  logic [PLEN-1:0] rat_prd;
  logic            fl_wen;
  logic [PLEN-1:0] fl_pr;
  logic            bpu_wen;
  logic [XLEN-1:0] bpu_pc;
  logic [XLEN-1:0] bpu_npc;
  logic            bpu_taken;
  logic            bpu_jr;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            icache_flush_req;
  logic            icache_flush_ack;
  logic            halt;
  logic [63:0]     perf_commit;
  logic [31:0]     perf_flush;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_fires   = 0;
  int exp_flushes = 0;

  ysyx_cmu_if #(.XLEN(XLEN), .PLEN(PLEN)) cmu_bus ();

  ysyx_cmu #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .clock            (clock),
    .reset            (reset),
    .cmu              (cmu_bus.slave),
    .rat_wen          (rat_wen),
    .rat_rd           (rat_rd),
    .rat_prd          (rat_prd),
    .fl_wen           (fl_wen),
    .fl_pr            (fl_pr),
    .bpu_wen          (bpu_wen),
    .bpu_pc           (bpu_pc),
    .bpu_npc          (bpu_npc),
    .bpu_taken        (bpu_taken),
    .bpu_jr           (bpu_jr),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .icache_flush_req (icache_flush_req),
    .icache_flush_ack (icache_flush_ack),
    .halt             (halt),
    .perf_commit      (perf_commit),
    .perf_flush       (perf_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_slot();
    cmu_bus.cmu_valid      = 1'b0;
    cmu_bus.cmu_rd         = '0;
    cmu_bus.cmu_inst       = '0;
    cmu_bus.cmu_pc         = '0;
    cmu_bus.cmu_npc        = '0;
    cmu_bus.cmu_btaken     = 1'b0;
    cmu_bus.cmu_ben        = 1'b0;
    cmu_bus.cmu_jen        = 1'b0;
    cmu_bus.cmu_jren       = 1'b0;
    cmu_bus.cmu_prd        = '0;
    cmu_bus.cmu_prs        = '0;
    cmu_bus.cmu_ebreak     = 1'b0;
    cmu_bus.cmu_fence_time = 1'b0;
    cmu_bus.cmu_fence_i    = 1'b0;
    cmu_bus.cmu_flush_pipe = 1'b0;
  endtask

  task automatic load_rd(input logic [4:0] rd, input logic [PLEN-1:0] prd, input logic [PLEN-1:0] prs);
    cmu_bus.cmu_valid = 1'b1;
    cmu_bus.cmu_rd    = rd;
    cmu_bus.cmu_prd   = prd;
    cmu_bus.cmu_prs   = prs;
  endtask

  task automatic check_perf(input string tag);
`ifdef YSYX_CMU_PERF_EN
    check({tag, "_perf_commit"}, perf_commit, 64'(exp_fires));
    check({tag, "_perf_flush"},  64'(perf_flush), 64'(exp_flushes));
`else
    check({tag, "_perf_commit"}, perf_commit, 64'd0);
    check({tag, "_perf_flush"},  64'(perf_flush), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_slot();
    icache_flush_ack = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_ready",    cmu_bus.cmu_ready, 1);
    check("rst_rat_wen",  rat_wen, 0);
    check("rst_fl_wen",   fl_wen, 0);
    check("rst_bpu_wen",  bpu_wen, 0);
    check("rst_flush",    flush, 0);
    check("rst_halt",     halt, 0);
    check("rst_ifreq",    icache_flush_req, 0);
    check("rst_rat_rd",   rat_rd, 0);
    check("rst_redirect", redirect_pc, 0);
    check_perf("rst");

    // rd=5 prd=12 prs=7
    load_rd(5'd5, 6'd12, 6'd7);
    tick(); exp_fires++;
    clear_slot();
    check("c1_rat_wen", rat_wen, 1);
    check("c1_rat_rd",  rat_rd, 5);
    check("c1_rat_prd", rat_prd, 12);
    check("c1_fl_wen",  fl_wen, 1);
    check("c1_fl_pr",   fl_pr, 7);
    check("c1_bpu_wen", bpu_wen, 0);
    check("c1_flush",   flush, 0);
    tick();
    check("c1_rat_wen_off", rat_wen, 0);
    check("c1_fl_wen_off",  fl_wen, 0);
    check("c1_rat_rd_hold", rat_rd, 5);

    // rd=0 never writes RAT nor frees prs
    load_rd(5'd0, 6'd3, 6'd9);
    tick(); exp_fires++;
    clear_slot();
    check("c2_rat_wen", rat_wen, 0);
    check("c2_fl_wen",  fl_wen, 0);
    check("c2_fl_hold", fl_pr, 7);

    // back-to-back fires
    load_rd(5'd1, 6'd20, 6'd0);
    tick(); exp_fires++;
    check("b2b1_rat_wen", rat_wen, 1);
    check("b2b1_rat_rd",  rat_rd, 1);
    check("b2b1_fl_wen",  fl_wen, 0);
    load_rd(5'd2, 6'd21, 6'd22);
    tick(); exp_fires++;
    clear_slot();
    check("b2b2_rat_wen", rat_wen, 1);
    check("b2b2_rat_prd", rat_prd, 21);
    check("b2b2_fl_wen",  fl_wen, 1);
    check("b2b2_fl_pr",   fl_pr, 22);

    // taken branch with pipeline flush
    cmu_bus.cmu_valid      = 1'b1;
    cmu_bus.cmu_pc         = 32'h8000_0010;
    cmu_bus.cmu_npc        = 32'h8000_0040;
    cmu_bus.cmu_btaken     = 1'b1;
    cmu_bus.cmu_ben        = 1'b1;
    cmu_bus.cmu_flush_pipe = 1'b1;
    tick(); exp_fires++; exp_flushes++;
    clear_slot();
    check("br_bpu_wen",  bpu_wen, 1);
    check("br_bpu_taken", bpu_taken, 1);
    check("br_bpu_pc",   bpu_pc, 64'h8000_0010);
    check("br_bpu_npc",  bpu_npc, 64'h8000_0040);
    check("br_bpu_jr",   bpu_jr, 0);
    check("br_flush",    flush, 1);
    check("br_redirect", redirect_pc, 64'h8000_0040);
    check("br_ready",    cmu_bus.cmu_ready, 1);
    tick();
    check("br_flush_off",   flush, 0);
    check("br_bpu_wen_off", bpu_wen, 0);
    check("br_redir_hold",  redirect_pc, 64'h8000_0040);

    // jalr, not-taken flag: taken forced by jren
    cmu_bus.cmu_valid = 1'b1;
    cmu_bus.cmu_pc    = 32'h0000_0100;
    cmu_bus.cmu_npc   = 32'h0000_0200;
    cmu_bus.cmu_jren  = 1'b1;
    tick(); exp_fires++;
    clear_slot();
    check("jr_bpu_wen",   bpu_wen, 1);
    check("jr_bpu_taken", bpu_taken, 1);
    check("jr_bpu_jr",    bpu_jr, 1);
    check("jr_flush",     flush, 0);

    // fence_time alone flushes
    cmu_bus.cmu_valid      = 1'b1;
    cmu_bus.cmu_npc        = 32'h0000_0300;
    cmu_bus.cmu_fence_time = 1'b1;
    tick(); exp_fires++; exp_flushes++;
    clear_slot();
    check("ft_flush",    flush, 1);
    check("ft_redirect", redirect_pc, 64'h300);
    check("ft_bpu_wen",  bpu_wen, 0);

    // stray ack in IDLE is ignored
    icache_flush_ack = 1'b1;
    tick();
    icache_flush_ack = 1'b0;
    check("stray_ack_flush", flush, 0);
    check("stray_ack_ifreq", icache_flush_req, 0);
    check("stray_ack_ready", cmu_bus.cmu_ready, 1);

    // fence.i with flush_pipe also set (suppressed), ack three cycles later
    load_rd(5'd3, 6'd30, 6'd31);
    cmu_bus.cmu_pc         = 32'h8000_0100;
    cmu_bus.cmu_npc        = 32'h8000_0104;
    cmu_bus.cmu_fence_i    = 1'b1;
    cmu_bus.cmu_flush_pipe = 1'b1;
    tick(); exp_fires++;
    clear_slot();
    load_rd(5'd9, 6'd1, 6'd2);
    check("fi1_rat_wen", rat_wen, 1);
    check("fi1_fl_wen",  fl_wen, 1);
    check("fi1_flush",   flush, 0);
    check("fi1_ifreq",   icache_flush_req, 1);
    check("fi1_ready",   cmu_bus.cmu_ready, 0);
    tick();
    check("fi2_ifreq",   icache_flush_req, 1);
    check("fi2_ready",   cmu_bus.cmu_ready, 0);
    check("fi2_rat_wen", rat_wen, 0);
    tick();
    check("fi3_ifreq",   icache_flush_req, 1);
    check("fi3_flush",   flush, 0);
    icache_flush_ack = 1'b1;
    clear_slot();
    tick(); exp_flushes++;
    icache_flush_ack = 1'b0;
    check("fi_done_flush",    flush, 1);
    check("fi_done_redirect", redirect_pc, 64'h8000_0104);
    check("fi_done_ifreq",    icache_flush_req, 0);
    check("fi_done_ready",    cmu_bus.cmu_ready, 1);
    check("fi_done_rat_wen",  rat_wen, 0);
    tick();
    check("fi_after_flush", flush, 0);

    // ebreak wins over fence.i and flush_pipe; valid stays high afterwards
    load_rd(5'd4, 6'd40, 6'd0);
    cmu_bus.cmu_npc        = 32'h0000_0500;
    cmu_bus.cmu_ebreak     = 1'b1;
    cmu_bus.cmu_fence_i    = 1'b1;
    cmu_bus.cmu_flush_pipe = 1'b1;
    tick(); exp_fires++;
    clear_slot();
    load_rd(5'd6, 6'd50, 6'd51);
    check("eb_halt",    halt, 1);
    check("eb_rat_wen", rat_wen, 1);
    check("eb_rat_rd",  rat_rd, 4);
    check("eb_flush",   flush, 0);
    check("eb_ifreq",   icache_flush_req, 0);
    check("eb_ready",   cmu_bus.cmu_ready, 0);
    tick();
    tick();
    check("eb_hold_halt",    halt, 1);
    check("eb_hold_rat_wen", rat_wen, 0);
    check("eb_hold_ready",   cmu_bus.cmu_ready, 0);
    check("eb_hold_rat_rd",  rat_rd, 4);
    check_perf("pre_rst");

    // reset releases HALT
    reset = 1'b1;
    clear_slot();
    tick();
    reset = 1'b0;
    exp_fires = 0;
    exp_flushes = 0;
    check("rst2_halt",     halt, 0);
    check("rst2_ready",    cmu_bus.cmu_ready, 1);
    check("rst2_rat_rd",   rat_rd, 0);
    check("rst2_redirect", redirect_pc, 0);
    check("rst2_bpu_pc",   bpu_pc, 0);
    check_perf("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_cmu.md
YSYX_CMU -- requirements
Module: ysyx_cmu

Interface
REQ-001 SHALL have parameter XLEN, default 32: architectural data/PC width.
REQ-002 SHALL have parameter PLEN, default 6: physical register index width.
REQ-003 SHALL have ports `clock`  in  1  (single clock) and `reset`  in  1  (synchronous, active-high).
REQ-004 SHALL have input group `cmu_valid` 1, `cmu_rd` 5, `cmu_inst` 32, `cmu_pc` XLEN, `cmu_npc` XLEN, `cmu_btaken` 1, `cmu_ben`/`cmu_jen`/`cmu_jren` 1 each, `cmu_prd`/`cmu_prs` PLEN each, `cmu_ebreak`/`cmu_fence_time`/`cmu_fence_i`/`cmu_flush_pipe` 1 each: the ROB commit slot.
REQ-005 SHALL have `cmu_ready`  out  1: commit slot accepted this cycle.
REQ-006 SHALL have `rat_wen` out 1, `rat_rd` out 5, `rat_prd` out PLEN: architectural RAT update.
REQ-007 SHALL have `fl_wen` out 1, `fl_pr` out PLEN: freed physical register to the free list.
REQ-008 SHALL have `bpu_wen` out 1, `bpu_pc` out XLEN, `bpu_npc` out XLEN, `bpu_taken` out 1, `bpu_jr` out 1: predictor training.
REQ-009 SHALL have `flush` out 1 and `redirect_pc` out XLEN: pipeline flush and refetch target.
REQ-010 SHALL have `icache_flush_req` out 1 and `icache_flush_ack` in 1: fence.i handshake.
REQ-011 SHALL have `halt` out 1: ebreak committed.
REQ-012 SHALL have `perf_commit` out 64 and `perf_flush` out 32: performance counters.

Function
REQ-013 Commit fires when `cmu_valid && cmu_ready`; all side-effect outputs are registered and appear exactly one cycle after the fire cycle.
REQ-014 FSM states IDLE, FENCE, HALT; `cmu_ready` = 1 only in IDLE.
REQ-015 Fire with `cmu_rd != 0`: pulse `rat_wen`, `rat_rd=cmu_rd`, `rat_prd=cmu_prd` for one cycle.
REQ-016 Fire with `cmu_rd != 0 && cmu_prs != 0`: pulse `fl_wen`, `fl_pr=cmu_prs`; `rd==0` never frees a register, even if `cmu_prs` is nonzero.
REQ-017 Fire with `cmu_ben | cmu_jen | cmu_jren`: pulse `bpu_wen`; `bpu_pc=cmu_pc`, `bpu_npc=cmu_npc`, `bpu_taken = cmu_btaken | cmu_jen | cmu_jren`, `bpu_jr=cmu_jren`.
REQ-018 Fire with `cmu_flush_pipe | cmu_fence_time` and not `cmu_fence_i`: pulse `flush`, `redirect_pc=cmu_npc`; FSM stays IDLE.
REQ-019 Fire with `cmu_fence_i`: RAT/free-list effects per REQ-015/016, no flush yet, IDLE->FENCE, latch `cmu_pc+4` (mod 2^XLEN).
REQ-020 In FENCE, `icache_flush_req` SHALL be held 1 until the cycle `icache_flush_ack`=1 is sampled.
REQ-021 On that ack cycle, `icache_flush_req` SHALL drop next cycle, `flush` SHALL pulse next cycle with `redirect_pc` = latched PC, and FENCE->IDLE.
REQ-022 An ack sampled while `icache_flush_req`=0 SHALL be ignored.
REQ-023 Fire with `cmu_ebreak`: other commit effects per REQ-015..017, IDLE->HALT, `halt`=1 from the next cycle and held until reset.
REQ-024 HALT is terminal: no further fires; `cmu_valid` ignored.
REQ-025 Precedence on a single fire: `cmu_ebreak` > `cmu_fence_i` > `cmu_flush_pipe`/`cmu_fence_time`; lower-priority flush/fence actions are suppressed.
REQ-026 Pulses (`rat_wen`, `fl_wen`, `bpu_wen`, `flush`) SHALL last exactly one cycle per event; back-to-back fires produce back-to-back pulses.
REQ-027 When a pulse is 0, its data outputs hold their last value.

Reset
REQ-028 On `reset`=1 at a clock edge, the FSM SHALL go to IDLE, and all pulse outputs, `icache_flush_req`, and `halt` SHALL be 0.
REQ-029 On reset, `rat_rd`, `rat_prd`, `fl_pr`, `bpu_*` data, `redirect_pc`, the latched PC and the counters SHALL be 0.
REQ-030 Reset during FENCE or HALT SHALL abort the operation with no flush pulse; `cmu_ready`=1 the cycle after reset deasserts.

Configuration
REQ-031 With `YSYX_CMU_PERF_EN` defined, `perf_commit` SHALL increment by 1 per fire, wrapping at 2^64.
REQ-032 With `YSYX_CMU_PERF_EN` defined, `perf_flush` SHALL increment by 1 per `flush` pulse, wrapping at 2^32.
REQ-033 Without `YSYX_CMU_PERF_EN`, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-034 Fire with rd=5, prd=12, prs=7 -> next cycle `rat_wen`=1, rd=5, prd=12; `fl_wen`=1, pr=7; one-cycle pulses.
REQ-035 Fire with rd=0, prs=9 -> no `rat_wen`, no `fl_wen`.
REQ-036 Fire branch: pc=0x80000010, npc=0x80000040, btaken=1, flush_pipe=1 -> next cycle `bpu_wen`=1, `bpu_taken`=1; `flush`=1, `redirect_pc`=0x80000040.
REQ-037 fence.i fire at pc=0x80000100, ack 3 cycles later -> `cmu_ready`=0 and `icache_flush_req`=1 for 3 cycles; `flush`=1 with `redirect_pc`=0x80000104 one cycle after ack.
REQ-038 ebreak fire, then `cmu_valid` held 1 -> `halt`=1 stays set, `cmu_ready`=0, no further `rat_wen`; `reset` pulse -> `halt`=0, `cmu_ready`=1.
REQ-039 With `YSYX_CMU_PERF_EN`: 10 fires including 2 flushes -> `perf_commit`=10, `perf_flush`=2; without the macro -> both 0.
